// File: rtl/subtractor_serial_4bits.sv
// Bit-serial subtractor D = A - B - Bin using one full-subtractor cell.
// One bit per clock, LSB first, behind a start/busy/done handshake.
module subtractor_serial_4bits #(
  parameter int WIDTH = 4
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  input  logic             i_w_bin,
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic [WIDTH-1:0] o_w_d,
  output logic             o_w_bout,
  output logic             o_w_zero,
  output logic             o_w_ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             r_bit;
  logic             nb;
  logic [WIDTH-1:0] res_nx;

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    d_d      = d_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    r_bit  = sa_q[0] ^ sb_q[0] ^ borrow_q;
    nb     = (~sa_q[0] & sb_q[0])
           | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
    res_nx = {r_bit, res_q[WIDTH-1:1]};

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request too, so back-to-back ops have no bubble
        if (i_w_start) begin
          sa_d     = i_w_a;
          sb_d     = i_w_b;
          borrow_d = i_w_bin;
          res_d    = '0;
          cnt_d    = '0;
          amsb_d   = i_w_a[WIDTH-1];
          bmsb_d   = i_w_b[WIDTH-1];
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        borrow_d = nb;
        res_d    = res_nx;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_d     = res_nx;
          bout_d  = nb;
          zero_d  = ~|res_nx;
          ovf_d   = (amsb_q ^ bmsb_q) & (r_bit ^ amsb_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_w_busy = (state_q == RUN);
  assign o_w_done = (state_q == DONE);
  assign o_w_d    = d_q;
  assign o_w_bout = bout_q;
  assign o_w_zero = zero_q;
  assign o_w_ovf  = ovf_q;

endmodule
